// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator call scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elevator_pkg;

  // Controller states. HALT is only reachable when the emergency-stop
  // build option ELEVATOR_SCHED_ESTOP_EN is defined.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR_OPEN = 3'd3,
    HALT      = 3'd4
  } state_e;

  localparam int NUM_FLOORS_DEF = 4;
  localparam int FLOOR_W_DEF    = $clog2(NUM_FLOORS_DEF);

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Call-panel / motor / door signal bundle for the elevator scheduler.
// Latency: wires only.
// Backpressure: none; calls are level/pulse inputs latched by the slave.
// Ports: call_req, floor_arrive (, estop) flow master->slave;
//        cur_floor, motor_up, motor_down, door_open, pending, dir_up flow slave->master.
// Build option: ELEVATOR_SCHED_ESTOP_EN adds the estop level input.
interface elevator_call_scheduler_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
);
  localparam int FW = $clog2(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] call_req;
  logic                  floor_arrive;
  logic [FW-1:0]         cur_floor;
  logic                  motor_up;
  logic                  motor_down;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;

`ifdef ELEVATOR_SCHED_ESTOP_EN
  logic                  estop;

  modport master (
    output call_req, floor_arrive, estop,
    input  cur_floor, motor_up, motor_down, door_open, pending, dir_up
  );
  modport slave (
    input  call_req, floor_arrive, estop,
    output cur_floor, motor_up, motor_down, door_open, pending, dir_up
  );
`else
  modport master (
    output call_req, floor_arrive,
    input  cur_floor, motor_up, motor_down, door_open, pending, dir_up
  );
  modport slave (
    input  call_req, floor_arrive,
    output cur_floor, motor_up, motor_down, door_open, pending, dir_up
  );
`endif

endinterface

// File: rtl/door_dwell_timer.sv
// Door dwell down-counter: load/reload to DOOR_CYCLES-1, count to zero.
// Latency: expire is combinational from the registered count.
// Backpressure: none; load always wins over decrement.
// Ports: clk, rst_n, load (start/restart dwell), en (door phase active),
//        expire (dwell finished this cycle and no reload requested).
module door_dwell_timer #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int            CW     = $clog2(DOOR_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(DOOR_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  // Loaded to DOOR_CYCLES-1, so the door phase lasts DOOR_CYCLES cycles.
  assign expire = en & ~load & (count == '0);

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler for the elevator car: latches calls, drives motor/door.
// Latency: call -> motor/door one cycle later; Moore outputs from state.
// Backpressure: none; calls are absorbed into pending until served.
// Ports: clk, rst_n (async active-low), bus (elevator_call_scheduler_if.slave).
// Build option: ELEVATOR_SCHED_ESTOP_EN adds estop and the HALT state.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  elevator_call_scheduler_if.slave  bus
);
  localparam int FW = $clog2(NUM_FLOORS);

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_UP   = MOVE_UP;
  localparam logic [2:0] S_DOWN = MOVE_DOWN;
  localparam logic [2:0] S_DOOR = DOOR_OPEN;
`ifdef ELEVATOR_SCHED_ESTOP_EN
  localparam logic [2:0] S_HALT = HALT;
`endif

  localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

  logic [2:0]            state, nxt_state;
  logic [FW-1:0]         floor_q, nxt_floor;
  logic                  dir_q, nxt_dir;
  logic [NUM_FLOORS-1:0] pend_q, pend_nxt;
  logic [NUM_FLOORS-1:0] req_all, served;
  logic [FW-1:0]         up_floor, dn_floor;
  logic                  any_up, any_dn, ahead, behind;
  logic                  tmr_load, tmr_expire;

  function automatic logic [NUM_FLOORS-1:0] above_of(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_of(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FW-1:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

  // New calls are visible in the cycle they arrive.
  assign req_all  = pend_q | bus.call_req;
  assign up_floor = floor_q + FW'(1);
  assign dn_floor = floor_q - FW'(1);
  assign any_up   = |(req_all & above_of(floor_q));
  assign any_dn   = |(req_all & below_of(floor_q));
  assign ahead    = dir_q ? any_up : any_dn;
  assign behind   = dir_q ? any_dn : any_up;

  always_comb begin
    nxt_state = state;
    nxt_floor = floor_q;
    nxt_dir   = dir_q;
    served    = '0;
    tmr_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_all[floor_q]) begin
          nxt_state = S_DOOR;
          tmr_load  = 1'b1;
          served    = onehot(floor_q);
        end else if (ahead) begin
          nxt_state = dir_q ? S_UP : S_DOWN;
        end else if (behind) begin
          nxt_dir   = ~dir_q;
          nxt_state = dir_q ? S_DOWN : S_UP;
        end
      end
      S_UP: begin
        if (bus.floor_arrive) begin
          if (floor_q == TOP_FLOOR) begin
            nxt_state = S_IDLE;
          end else begin
            nxt_floor = up_floor;
            if (req_all[up_floor]) begin
              nxt_state = S_DOOR;
              tmr_load  = 1'b1;
              served    = onehot(up_floor);
            end else if (~|(req_all & above_of(up_floor))) begin
              nxt_state = S_IDLE;
            end
          end
        end
      end
      S_DOWN: begin
        if (bus.floor_arrive) begin
          if (floor_q == '0) begin
            nxt_state = S_IDLE;
          end else begin
            nxt_floor = dn_floor;
            if (req_all[dn_floor]) begin
              nxt_state = S_DOOR;
              tmr_load  = 1'b1;
              served    = onehot(dn_floor);
            end else if (~|(req_all & below_of(dn_floor))) begin
              nxt_state = S_IDLE;
            end
          end
        end
      end
      S_DOOR: begin
        // A hall call at the open floor is absorbed: it extends the dwell
        // and is masked out of pending.
        served = onehot(floor_q);
        if (bus.call_req[floor_q]) begin
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          if (ahead) begin
            nxt_state = dir_q ? S_UP : S_DOWN;
          end else if (behind) begin
            nxt_dir   = ~dir_q;
            nxt_state = dir_q ? S_DOWN : S_UP;
          end else begin
            nxt_state = S_IDLE;
          end
        end
      end
`ifdef ELEVATOR_SCHED_ESTOP_EN
      S_HALT: begin
        if (!bus.estop) nxt_state = S_IDLE;
      end
`endif
      default: nxt_state = S_IDLE;
    endcase

    pend_nxt = req_all & ~served;

`ifdef ELEVATOR_SCHED_ESTOP_EN
    // Emergency stop overrides everything; position and direction are kept.
    if (bus.estop) begin
      nxt_state = S_HALT;
      nxt_floor = floor_q;
      nxt_dir   = dir_q;
      tmr_load  = 1'b0;
    end
    if (bus.estop || (state == S_HALT)) pend_nxt = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      floor_q <= '0;
      dir_q   <= 1'b1;
      pend_q  <= '0;
    end else begin
      state   <= nxt_state;
      floor_q <= nxt_floor;
      dir_q   <= nxt_dir;
      pend_q  <= pend_nxt;
    end
  end

  door_dwell_timer #(
    .DOOR_CYCLES (DOOR_CYCLES)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (state == S_DOOR),
    .expire (tmr_expire)
  );

  assign bus.cur_floor  = floor_q;
  assign bus.motor_up   = (state == S_UP);
  assign bus.motor_down = (state == S_DOWN);
  assign bus.door_open  = (state == S_DOOR);
  assign bus.pending    = pend_q;
  assign bus.dir_up     = dir_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler (4 floors, 8-cycle dwell).
// Latency: n/a.
// Backpressure: n/a.
module tb_elevator_call_scheduler;
  localparam int NF   = 4;
  localparam int DOOR = 8;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   run = 1'b0;
  int   checks = 0;
  int   errors = 0;

  elevator_call_scheduler_if #(.NUM_FLOORS(NF)) bus();

  elevator_call_scheduler #(
    .NUM_FLOORS  (NF),
    .DOOR_CYCLES (DOOR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_floor;
  bit          m_up;
  logic [NF-1:0] m_pend;
  int          m_mode;
  int          m_left;   // door cycles still to show, counting the current one

  function automatic bit has_above(input int f, input logic [NF-1:0] r);
    for (int i = f + 1; i < NF; i++) if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit has_below(input int f, input logic [NF-1:0] r);
    for (int i = 0; i < f; i++) if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Pick the next travel leg: keep direction if calls lie ahead, else reverse.
  task automatic pick_leg(input logic [NF-1:0] r);
    bit up_calls = has_above(m_floor, r);
    bit dn_calls = has_below(m_floor, r);
    if (m_up ? up_calls : dn_calls) m_mode = m_up ? M_UP : M_DOWN;
    else if (m_up ? dn_calls : up_calls) begin
      m_up   = !m_up;
      m_mode = m_up ? M_UP : M_DOWN;
    end else m_mode = M_IDLE;
  endtask

  task automatic model_step(input logic [NF-1:0] c, input logic fa);
    logic [NF-1:0] r = m_pend | c;
    int served = -1;
    case (m_mode)
      M_IDLE: begin
        if (r[m_floor]) begin
          m_mode = M_DOOR; m_left = DOOR; served = m_floor;
        end else pick_leg(r);
      end
      M_UP, M_DOWN: begin
        if (fa) begin
          if ((m_mode == M_UP && m_floor == NF - 1) || (m_mode == M_DOWN && m_floor == 0))
            m_mode = M_IDLE;
          else begin
            m_floor = m_floor + ((m_mode == M_UP) ? 1 : -1);
            if (r[m_floor]) begin
              m_mode = M_DOOR; m_left = DOOR; served = m_floor;
            end else if (m_mode == M_UP ? !has_above(m_floor, r) : !has_below(m_floor, r))
              m_mode = M_IDLE;
          end
        end
      end
      default: begin
        served = m_floor;
        if (c[m_floor]) m_left = DOOR;
        else begin
          m_left--;
          if (m_left == 0) pick_leg(r);
        end
      end
    endcase
    m_pend = r;
    if (served >= 0) m_pend[served] = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_floor = 0; m_up = 1'b1; m_pend = '0; m_mode = M_IDLE; m_left = 0;
    end else begin
      model_step(bus.call_req, bus.floor_arrive);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run && rst_n) begin
      chk("m.cur_floor",  32'(bus.cur_floor), 32'(m_floor));
      chk("m.motor_up",   32'(bus.motor_up),  32'(m_mode == M_UP));
      chk("m.motor_down", 32'(bus.motor_down), 32'(m_mode == M_DOWN));
      chk("m.door_open",  32'(bus.door_open), 32'(m_mode == M_DOOR));
      chk("m.pending",    32'(bus.pending),   32'(m_pend));
      chk("m.dir_up",     32'(bus.dir_up),    32'(m_up));
      chk("m.exclusive",  32'(32'(bus.motor_up) + 32'(bus.motor_down) + 32'(bus.door_open) <= 1), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic [NF-1:0] c, input logic fa);
    bus.call_req     = c;
    bus.floor_arrive = fa;
    @(posedge clk); #1;
    bus.call_req     = '0;
    bus.floor_arrive = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, 1'b0);
  endtask

  task automatic door_len(input string nm, input int exp_n);
    int n = 0;
    while (bus.door_open === 1'b1 && n < 40) begin
      n++;
      tick('0, 1'b0);
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  initial begin
    bus.call_req     = '0;
    bus.floor_arrive = 1'b0;
`ifdef ELEVATOR_SCHED_ESTOP_EN
    bus.estop        = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cur_floor", 32'(bus.cur_floor), 32'd0);
    chk("rst.dir_up",    32'(bus.dir_up),    32'd1);
    chk("rst.pending",   32'(bus.pending),   32'd0);
    chk("rst.outputs",   32'({bus.motor_up, bus.motor_down, bus.door_open}), 32'd0);
    rst_n = 1'b1;
    run   = 1'b1;

    // Single call to the top floor.
    tick(4'b1000, 1'b0);
    chk("t1.motor_up", 32'(bus.motor_up), 32'd1);
    chk("t1.pending",  32'(bus.pending),  32'h8);
    idle(2);
    tick('0, 1'b1);
    chk("t1.floor1", 32'(bus.cur_floor), 32'd1);
    idle(1);
    tick('0, 1'b1);
    tick('0, 1'b1);
    chk("t1.floor3",    32'(bus.cur_floor), 32'd3);
    chk("t1.door",      32'({bus.door_open, bus.motor_up}), 32'b10);
    door_len("t1.dwell", DOOR);
    chk("t1.idle_out",  32'({bus.motor_up, bus.motor_down, bus.door_open}), 32'd0);
    chk("t1.pend_clr",  32'(bus.pending), 32'd0);

    // Go back to floor 0 (direction flips down).
    tick(4'b0001, 1'b0);
    chk("t2.flip_down", 32'({bus.dir_up, bus.motor_down}), 32'b01);
    tick('0, 1'b1); tick('0, 1'b1); tick('0, 1'b1);
    door_len("t2.dwell0", DOOR);

    // Calls at 1 and 3 from floor 0; dwell reload at floor 1.
    tick(4'b1010, 1'b0);
    chk("t2.flip_up",  32'({bus.dir_up, bus.motor_up}), 32'b11);
    chk("t2.pend13",   32'(bus.pending), 32'hA);
    tick('0, 1'b1);
    chk("t2.stop1",    32'({bus.door_open, 2'(bus.cur_floor)}), 32'b101);
    chk("t2.pend3",    32'(bus.pending), 32'h8);
    idle(4);
    tick(4'b0010, 1'b0);
    chk("t4.no_pend1", 32'(bus.pending), 32'h8);
    door_len("t4.reload", DOOR);
    chk("t2.resume",   32'({bus.dir_up, bus.motor_up}), 32'b11);
    tick('0, 1'b1);
    tick('0, 1'b1);
    chk("t2.stop3",    32'({bus.door_open, bus.dir_up, 2'(bus.cur_floor)}), 32'b1111);
    door_len("t2.dwell3", DOOR);

    // Call coinciding with arrival at floor 2 while going down.
    tick(4'b0001, 1'b0);
    idle(1);
    tick(4'b0100, 1'b1);
    chk("t5.door2",    32'({bus.door_open, bus.motor_down, 2'(bus.cur_floor)}), 32'b1010);
    chk("t5.pend",     32'(bus.pending), 32'h1);
    door_len("t5.dwell", DOOR);
    tick('0, 1'b1); tick('0, 1'b1);
    door_len("t5.dwell0", DOOR);
    tick('0, 1'b1);
    chk("idle.arrive_ign", 32'({2'(bus.cur_floor), bus.motor_down}), 32'd0);

    // Car at 2 heading up, calls at 0 and 3: serve 3 first, then reverse.
    tick(4'b0100, 1'b0);
    tick('0, 1'b1); tick('0, 1'b1);
    chk("t3.at2",      32'({bus.door_open, bus.dir_up, 2'(bus.cur_floor)}), 32'b1110);
    tick(4'b1001, 1'b0);
    chk("t3.pend",     32'(bus.pending), 32'h9);
    door_len("t3.dwell2", DOOR - 1);
    chk("t3.up",       32'(bus.motor_up), 32'd1);
    tick('0, 1'b1);
    chk("t3.at3",      32'({bus.door_open, 2'(bus.cur_floor)}), 32'b111);
    door_len("t3.dwell3", DOOR);
    chk("t3.flip",     32'({bus.dir_up, bus.motor_down}), 32'b01);
    tick('0, 1'b1); tick('0, 1'b1); tick('0, 1'b1);
    chk("t3.at0",      32'({bus.door_open, 2'(bus.cur_floor), 4'(bus.pending)}), 32'b1000000);
    door_len("t3.dwell0", DOOR);

    // Reset in the middle of a run.
    tick(4'b1000, 1'b0);
    tick('0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst2.state", 32'({2'(bus.cur_floor), bus.motor_up, bus.door_open, 4'(bus.pending), bus.dir_up}), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick('0, 1'b0);
    chk("rst2.still", 32'({bus.motor_up, bus.motor_down}), 32'd0);

`ifdef ELEVATOR_SCHED_ESTOP_EN
    tick(4'b1000, 1'b0);
    tick('0, 1'b1); tick('0, 1'b1); tick('0, 1'b1);
    door_len("es.dwell3", DOOR);
    tick(4'b0011, 1'b0);
    run = 1'b0;
    bus.estop = 1'b1;
    tick('0, 1'b0);
    chk("es.halt_out",  32'({bus.motor_up, bus.motor_down, bus.door_open}), 32'd0);
    chk("es.halt_pend", 32'(bus.pending), 32'd0);
    tick(4'b0100, 1'b0);
    chk("es.ign_call",  32'(bus.pending), 32'd0);
    bus.estop = 1'b0;
    tick('0, 1'b0);
    chk("es.release",   32'({2'(bus.cur_floor), bus.motor_up, bus.motor_down, bus.door_open}), 32'b11000);
`endif

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
